spline_interp_pipe: RTL

Pipelined, parametrised piecewise-polynomial envelope interpolator for the EMD sifting datapath. It accepts one segment descriptor at a time: coefficients A..D, knot indices P1/P2 and a mode. It then streams one interpolated sample per clock for every index x in [P1, P2). The block generalises the single-segment linear spline stage with runtime linear, cubic or bypass modes, parametrised widths, back-to-back segment acceptance, and saturating fixed-point arithmetic.

---
 rtl/spline_interp_pipe.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/spline_interp_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spline_interp_pipe: pipelined Horner-form linear/cubic/bypass interpolator |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module spline_interp_pipe #(
  parameter int DW   = 20,
  parameter int XW   = 16,
  parameter int FRAC = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 seg_valid,
  output logic                 seg_ready,
  input  logic [1:0]           mode,
  input  logic signed [DW-1:0] A,
  input  logic signed [DW-1:0] B,
  input  logic signed [DW-1:0] C,
  input  logic signed [DW-1:0] D,
  input  logic [XW-1:0]        P1,
  input  logic [XW-1:0]        P2,
  input  logic signed [DW-1:0] xin,
  output logic signed [DW-1:0] Xout,
  output logic                 xout_valid,
  output logic [XW-1:0]        x_out,
  output logic                 seg_done,
  output logic                 follow_start
);

  localparam int ACC = DW + XW;
  localparam int PW  = ACC + XW + 2;

  localparam logic signed [PW-1:0] ACC_MAX = $signed({{(PW-ACC+1){1'b0}}, {(ACC-1){1'b1}}});
  localparam logic signed [PW-1:0] ACC_MIN = $signed({{(PW-ACC+1){1'b1}}, {(ACC-1){1'b0}}});
  localparam logic signed [PW-1:0] DW_MAX  = $signed({{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}});
  localparam logic signed [PW-1:0] DW_MIN  = $signed({{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}});

  localparam logic [1:0] MODE_CUBIC  = 2'b01;
  localparam logic [1:0] MODE_BYPASS = 2'b10;

  // One Horner step: base + (k*t >>> FRAC), full precision kept before the shift.
  function automatic logic signed [PW-1:0] mac(input logic signed [ACC-1:0] base,
                                               input logic signed [ACC-1:0] k,
                                               input logic [XW-1:0]         t);
    logic signed [PW-1:0] prod;
    prod = PW'(k) * $signed(PW'(t));
    return (prod >>> FRAC) + PW'(base);
  endfunction

  function automatic logic signed [ACC-1:0] sat_acc(input logic signed [PW-1:0] v);
    if (v > ACC_MAX) return ACC_MAX[ACC-1:0];
    if (v < ACC_MIN) return ACC_MIN[ACC-1:0];
    return v[ACC-1:0];
  endfunction

  function automatic logic signed [DW-1:0] sat_dw(input logic signed [PW-1:0] v);
    if (v > DW_MAX) return DW_MAX[DW-1:0];
    if (v < DW_MIN) return DW_MIN[DW-1:0];
    return v[DW-1:0];
  endfunction

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t state, state_nxt;

  logic [XW-1:0]        cnt, lp1, lp2;
  logic [1:0]           lmode;
  logic signed [DW-1:0] la, lb, lc, ld;
  logic                 tok_pend;
  logic                 accept, last, issue, nonempty;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    seg_ready = 1'b0;
    issue     = (state == RUN);
    last      = (cnt == (lp2 - XW'(1)));
    nonempty  = (P2 > P1);
    case (state)
      IDLE:    seg_ready = 1'b1;
      RUN:     seg_ready = last;
      default: seg_ready = 1'b0;
    endcase
    accept = seg_valid & seg_ready;
    if (accept)                    state_nxt = nonempty ? RUN : IDLE;
    else if (state == RUN && last) state_nxt = IDLE;
  end

  // Pipeline: issue -> s1 -> (h1) s2 -> (h2) s3 -> (y) output register.
  logic                  s1_valid, s1_done, s2_valid, s2_done, s3_valid, s3_done;
  logic [XW-1:0]         s1_t, s1_x, s2_t, s2_x, s3_t, s3_x;
  logic [1:0]            s1_mode, s2_mode, s3_mode;
  logic signed [DW-1:0]  s1_a, s1_b, s1_c, s1_d, s1_xin;
  logic signed [DW-1:0]  s2_a, s2_b, s2_xin, s3_a, s3_xin;
  logic signed [ACC-1:0] s2_h1, s3_h2;
  logic signed [ACC-1:0] h1_n, h2_n;
  logic signed [DW-1:0]  y_n;

  always_comb begin
    h1_n = '0;
    if (s1_mode == MODE_CUBIC) h1_n = sat_acc(mac(ACC'(s1_c), ACC'(s1_d), s1_t));
    h2_n = sat_acc(mac(ACC'(s2_b), s2_h1, s2_t));
    y_n  = sat_dw(mac(ACC'(s3_a), s3_h2, s3_t));
    if (s3_mode == MODE_BYPASS) y_n = s3_xin;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0; lp1 <= '0; lp2 <= '0; lmode <= '0;
      la <= '0; lb <= '0; lc <= '0; ld <= '0;
      tok_pend <= 1'b0;
      s1_valid <= 1'b0; s1_done <= 1'b0; s1_t <= '0; s1_x <= '0; s1_mode <= '0;
      s1_a <= '0; s1_b <= '0; s1_c <= '0; s1_d <= '0; s1_xin <= '0;
      s2_valid <= 1'b0; s2_done <= 1'b0; s2_t <= '0; s2_x <= '0; s2_mode <= '0;
      s2_a <= '0; s2_b <= '0; s2_xin <= '0; s2_h1 <= '0;
      s3_valid <= 1'b0; s3_done <= 1'b0; s3_t <= '0; s3_x <= '0; s3_mode <= '0;
      s3_a <= '0; s3_xin <= '0; s3_h2 <= '0;
      Xout <= '0; x_out <= '0; xout_valid <= 1'b0; seg_done <= 1'b0; follow_start <= 1'b0;
    end else begin
      tok_pend <= accept & ~nonempty;
      if (accept) begin
        lmode <= mode; la <= A; lb <= B; lc <= C; ld <= D;
        lp1 <= P1; lp2 <= P2; cnt <= P1;
      end else if (issue) begin
        cnt <= cnt + XW'(1);
      end

      // An empty segment is a done-only token issued the edge after its accept.
      s1_valid <= issue;
      s1_done  <= (issue & last) | tok_pend;
      s1_t     <= cnt - lp1;
      s1_x     <= cnt;
      s1_mode  <= lmode;
      s1_a <= la; s1_b <= lb; s1_c <= lc; s1_d <= ld;
      s1_xin   <= xin;

      s2_valid <= s1_valid; s2_done <= s1_done; s2_t <= s1_t; s2_x <= s1_x;
      s2_mode  <= s1_mode; s2_a <= s1_a; s2_b <= s1_b; s2_xin <= s1_xin;
      s2_h1    <= h1_n;

      s3_valid <= s2_valid; s3_done <= s2_done; s3_t <= s2_t; s3_x <= s2_x;
      s3_mode  <= s2_mode; s3_a <= s2_a; s3_xin <= s2_xin;
      s3_h2    <= h2_n;

      xout_valid <= s3_valid;
      seg_done   <= s3_done;
      if (s3_valid) begin
        Xout  <= y_n;
        x_out <= s3_x;
      end
      if (s3_done) follow_start <= 1'b1;
    end
  end

endmodule
`default_nettype wire
